// File: rtl/pe_simd_pipe.sv
// Purpose: packed-SIMD lane PE (8/16/32b lanes) with optional signed saturation, min/max and a sticky vxsat flag.
// Latency: 2 cycles from in_valid&&in_ready to out_valid; one bundle per cycle when not stalled.
// Backpressure: valid/ready; in_ready drops only when both stages are full and out_ready=0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   operand bundle handshake (a=vs2, b=vs1/shift amounts, c=vd addend)
//   op, vsew, saturate  operation, lane width select (3 behaves as 2), signed saturation enable
//   minmax              0/3 = op result, 1 = signed max(a,b), 2 = signed min(a,b)
//   out_valid/out_ready result handshake, out = packed lane results
//   sat_flag, sat_clr   sticky "a delivered result saturated" flag and its clear

package pe_simd_pkg;
    typedef enum logic [3:0] {
        PE_ADD, PE_SUB, PE_LSHIFT, PE_MUL, PE_MULADD,
        PE_XOR, PE_RSHIFT_LOG, PE_RSHIFT_AR, PE_OR, PE_AND
    } pe_arith_op_t;
endpackage

module pe_simd_pipe
    import pe_simd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  pe_arith_op_t      op,
    input  logic [1:0]        vsew,
    input  logic              saturate,
    input  logic [1:0]        minmax,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              sat_flag,
    input  logic              sat_clr
);

    // All three lane widths are computed in parallel; vsew picks one afterwards.
    logic [DATA_W-1:0] sew_res [3];
    logic [2:0]        sew_sat;

    // min/max reuses the subtractor as a comparator
    logic do_sub;
    assign do_sub = (op == PE_SUB) || (minmax == 2'd1) || (minmax == 2'd2);

    for (genvar g = 0; g < 3; g++) begin : g_sew
        localparam int SEW = 8 << g;
        localparam int NL  = DATA_W / SEW;
        localparam int SH  = $clog2(SEW);
        localparam logic [SEW-1:0] SMAX = {1'b0, {(SEW-1){1'b1}}};
        localparam logic [SEW-1:0] SMIN = {1'b1, {(SEW-1){1'b0}}};

        logic [DATA_W-1:0] res;
        logic [NL-1:0]     lane_sat;

        for (genvar l = 0; l < NL; l++) begin : g_lane
            logic [SEW-1:0]   la, lb, lc, r;
            logic [SEW:0]     sum;
            logic [2*SEW:0]   la_x, lb_x, lc_x, prod;
            logic [SH-1:0]    amt;
            logic             s, sum_ovf, prod_ovf;

            assign la  = a[l*SEW +: SEW];
            assign lb  = b[l*SEW +: SEW];
            assign lc  = c[l*SEW +: SEW];
            assign amt = lb[SH-1:0];

            // SEW+1 bits hold any sum/difference of two signed SEW values exactly
            assign sum = do_sub ? ({la[SEW-1], la} - {lb[SEW-1], lb})
                                : ({la[SEW-1], la} + {lb[SEW-1], lb});

            // Sign-extend to 2*SEW+1 so the product plus addend is exact
            assign la_x = {{(SEW+1){la[SEW-1]}}, la};
            assign lb_x = {{(SEW+1){lb[SEW-1]}}, lb};
            assign lc_x = {{(SEW+1){lc[SEW-1]}}, lc};
            assign prod = la_x * lb_x + ((op == PE_MULADD) ? lc_x : '0);

            // Overflow when the bits above the SEW-bit sign position disagree with it
            assign sum_ovf  = sum[SEW] ^ sum[SEW-1];
            assign prod_ovf = !((&prod[2*SEW:SEW-1]) || !(|prod[2*SEW:SEW-1]));

            always_comb begin
                r = '0;
                s = 1'b0;
                if (minmax == 2'd1) begin
                    r = sum[SEW] ? lb : la;
                end else if (minmax == 2'd2) begin
                    r = sum[SEW] ? la : lb;
                end else begin
                    case (op)
                        PE_ADD, PE_SUB: begin
                            if (saturate && sum_ovf) begin
                                r = sum[SEW] ? SMIN : SMAX;
                                s = 1'b1;
                            end else begin
                                r = sum[SEW-1:0];
                            end
                        end
                        PE_MUL, PE_MULADD: begin
                            if (saturate && prod_ovf) begin
                                r = prod[2*SEW] ? SMIN : SMAX;
                                s = 1'b1;
                            end else begin
                                r = prod[SEW-1:0];
                            end
                        end
                        PE_LSHIFT:     r = la << amt;
                        PE_RSHIFT_LOG: r = la >> amt;
                        PE_RSHIFT_AR:  r = $signed(la) >>> amt;
                        PE_XOR:        r = la ^ lb;
                        PE_OR:         r = la | lb;
                        PE_AND:        r = la & lb;
                        default:       r = '0;
                    endcase
                end
            end

            assign res[l*SEW +: SEW] = r;
            assign lane_sat[l]       = s;
        end

        assign sew_res[g] = res;
        assign sew_sat[g] = |lane_sat;
    end

    logic [DATA_W-1:0] lane_res;
    logic              lane_any_sat;

    always_comb begin
        lane_res     = sew_res[2];
        lane_any_sat = sew_sat[2];
        case (vsew)
            2'd0: begin lane_res = sew_res[0]; lane_any_sat = sew_sat[0]; end
            2'd1: begin lane_res = sew_res[1]; lane_any_sat = sew_sat[1]; end
            default: begin lane_res = sew_res[2]; lane_any_sat = sew_sat[2]; end
        endcase
    end

    // Two-stage pipeline; an empty stage always accepts so bubbles collapse.
    logic              s1_valid, s1_sat, s2_sat;
    logic [DATA_W-1:0] s1_dat;
    logic              s1_load, s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_dat    <= '0;
            s1_sat    <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            s2_sat    <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_dat <= lane_res;
                    s1_sat <= lane_any_sat;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out    <= s1_dat;
                    s2_sat <= s1_sat;
                end
            end
            // set has priority over a simultaneous clear
            if (out_valid && out_ready && s2_sat) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule
